// File: rtl/gate_bist_pkg.sv
// Shared definitions for the basic-gates BIST controller: FSM states,
// response bit positions and a small popcount helper.
package gate_bist_pkg;

    localparam int NUM_GATES = 7;
    localparam int NUM_VEC   = 4;
    localparam int ERR_W     = 5;

    localparam int AND_IDX  = 0;
    localparam int OR_IDX   = 1;
    localparam int NOT_IDX  = 2;
    localparam int NAND_IDX = 3;
    localparam int NOR_IDX  = 4;
    localparam int XOR_IDX  = 5;
    localparam int XNOR_IDX = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_t;

    // Number of set bits in one 7-bit response difference (0..7).
    function automatic logic [2:0] popcount7(input logic [NUM_GATES-1:0] v);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < NUM_GATES; i++) begin
            cnt = cnt + {2'b00, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gate_bist_ctrl_if.sv
// Handshake/result bundle between the BIST controller (slave side) and
// whatever sequences it and hosts the gates under test (master side).
interface gate_bist_ctrl_if;
    import gate_bist_pkg::*;

    logic                 start;
    logic                 a_o;
    logic                 b_o;
    logic [NUM_GATES-1:0] gate_i;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ERR_W-1:0]     err_cnt;
    logic [NUM_VEC-1:0]   fail_vec;

    modport master (
        output start, gate_i,
        input  a_o, b_o, busy, done, pass, err_cnt, fail_vec
    );

    modport slave (
        input  start, gate_i,
        output a_o, b_o, busy, done, pass, err_cnt, fail_vec
    );

endinterface

// File: rtl/gate_bist_ref.sv
// Golden model of the basic-gates block: the 7 responses expected for the
// operand pair currently being applied.
module gate_bist_ref
    import gate_bist_pkg::*;
(
    input  logic                 a,
    input  logic                 b,
    output logic [NUM_GATES-1:0] expected
);

    // Truth of each gate for the present operands.
    always_comb begin
        expected           = '0;
        expected[AND_IDX]  = a & b;
        expected[OR_IDX]   = a | b;
        expected[NOT_IDX]  = ~a;
        expected[NAND_IDX] = ~(a & b);
        expected[NOR_IDX]  = ~(a | b);
        expected[XOR_IDX]  = a ^ b;
        expected[XNOR_IDX] = ~(a ^ b);
    end

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer for a basic-gates block. Walks the four operand pairs
// 00,01,10,11, holds each for SETTLE cycles, compares the sampled gate
// responses against gate_bist_ref and accumulates a mismatch count and a
// per-vector failure map.
// Optional build macro: GATE_BIST_STOP_ON_FAIL_EN -- when defined, the run
// ends on the sample edge of the first vector showing any mismatch.
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int SETTLE = 2
)(
    input  logic             clk,
    input  logic             rst_n,
    gate_bist_ctrl_if.slave  bus
);

`ifdef GATE_BIST_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    bist_state_t          state;
    logic [3:0]           settle_cnt;
    logic [1:0]           vec_idx;
    logic                 a_q;
    logic                 b_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic [ERR_W-1:0]     err_q;
    logic [NUM_VEC-1:0]   fail_q;

    logic [NUM_GATES-1:0] exp_resp;
    logic [NUM_GATES-1:0] diff;
    logic [ERR_W-1:0]     err_next;
    logic                 sample_now;
    logic                 last_vec;

    gate_bist_ref u_ref (
        .a        (a_q),
        .b        (b_q),
        .expected (exp_resp)
    );

    // Compare the live response against the golden one and decide whether
    // this sample edge closes the run.
    always_comb begin
        diff       = bus.gate_i ^ exp_resp;
        err_next   = err_q + {2'b00, popcount7(diff)};
        sample_now = (state == RUN) && (settle_cnt == SETTLE_LAST);
        last_vec   = (vec_idx == 2'd3) || (STOP_ON_FAIL && (diff != '0));
    end

    // Run sequencer: IDLE waits for start, RUN steps the vectors and
    // scores each one, DONE emits the one-cycle completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= 4'd0;
            vec_idx    <= 2'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            fail_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state      <= RUN;
                        busy_q     <= 1'b1;
                        err_q      <= '0;
                        fail_q     <= '0;
                        vec_idx    <= 2'd0;
                        settle_cnt <= 4'd0;
                        a_q        <= 1'b0;
                        b_q        <= 1'b0;
                    end
                end
                RUN: begin
                    if (sample_now) begin
                        err_q <= err_next;
                        if (diff != '0) begin
                            fail_q <= fail_q | (4'b0001 << vec_idx);
                        end
                        if (last_vec) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            a_q    <= 1'b0;
                            b_q    <= 1'b0;
                            pass_q <= (err_next == '0);
                        end else begin
                            vec_idx      <= vec_idx + 2'd1;
                            {a_q, b_q}   <= vec_idx + 2'd1;
                            settle_cnt   <= 4'd0;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a_o      = a_q;
    assign bus.b_o      = b_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.err_cnt  = err_q;
    assign bus.fail_vec = fail_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Testbench for gate_bist_ctrl. A gate block is emulated from plain boolean
// operators plus a per-vector fault mask; the expected run result is derived
// from the masks alone. Honours GATE_BIST_STOP_ON_FAIL_EN like the design.
module tb_gate_bist_ctrl;

    localparam int SETTLE      = 2;
    localparam int CYCLE_LIMIT = 60;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    logic [6:0] fault_mask [4];

    gate_bist_ctrl_if bus ();

    gate_bist_ctrl #(.SETTLE(SETTLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10-time-unit clock; outputs are sampled on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal gate truth for operands {a,b}: [6]xnor [5]xor [4]nor [3]nand [2]not a [1]or [0]and.
    function automatic logic [6:0] golden(input logic [1:0] v);
        logic a;
        logic b;
        a = v[1];
        b = v[0];
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    endfunction

    // The emulated gate block: ideal response with the fault mask for the applied vector flipped in.
    assign bus.gate_i = golden({bus.a_o, bus.b_o}) ^ fault_mask[{bus.a_o, bus.b_o}];

    // One comparison; counts and reports any disagreement.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Run one full BIST pass against the current fault masks, optionally
    // re-pulsing start at a given cycle, and score timing and results.
    task automatic applyStimulus(input string name, input int repulse_at);
        int         exp_err;
        int         exp_last;
        int         exp_done;
        logic [3:0] exp_fail;
        bit         stopped;
        int         busy_cnt;
        int         done_cnt;
        int         first_done;
        int         bad_vec;
        int         bad_done;
        int         k;

        exp_err  = 0;
        exp_fail = 4'b0000;
        exp_last = 3;
        stopped  = 1'b0;
        for (int v = 0; v < 4; v++) begin
            if (!stopped) begin
                exp_err += $countones(fault_mask[v]);
                if (fault_mask[v] != 7'd0) begin
                    exp_fail[v] = 1'b1;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
                    stopped  = 1'b1;
                    exp_last = v;
`endif
                end
            end
        end
        exp_done = (exp_last + 1) * SETTLE + 1;

        busy_cnt   = 0;
        done_cnt   = 0;
        first_done = 0;
        bad_vec    = 0;
        bad_done   = 0;

        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 1; c <= CYCLE_LIMIT; c++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) begin
                busy_cnt++;
                k = (c - 1) / SETTLE;
                if ({bus.a_o, bus.b_o} !== 2'(k)) bad_vec++;
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (first_done == 0) first_done = c;
                if (bus.busy !== 1'b0 || bus.a_o !== 1'b0 || bus.b_o !== 1'b0) bad_done++;
            end
            bus.start = (c == repulse_at);
            if (first_done != 0 && c >= first_done + 2) break;
        end
        bus.start = 1'b0;

        checkOutput({name, "_done_seen"},   32'(first_done != 0), 32'd1);
        checkOutput({name, "_done_cycle"},  32'(first_done), 32'(exp_done));
        checkOutput({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_done - 1));
        checkOutput({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
        checkOutput({name, "_vector_seq"},  32'(bad_vec), 32'd0);
        checkOutput({name, "_done_state"},  32'(bad_done), 32'd0);
        checkOutput({name, "_err_cnt"},     32'(bus.err_cnt), 32'(exp_err));
        checkOutput({name, "_fail_vec"},    32'(bus.fail_vec), 32'(exp_fail));
        checkOutput({name, "_pass"},        32'(bus.pass), 32'(exp_err == 0));
    endtask

    // Directed sequence: reset, known fault patterns, start handling,
    // mid-run reset, then randomized fault masks.
    initial begin
        bit seen;
        int first_done;

        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b1;
        bus.start  = 1'b0;
        for (int v = 0; v < 4; v++) fault_mask[v] = 7'd0;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_state",
                    32'({bus.busy, bus.done, bus.pass, bus.a_o, bus.b_o, bus.err_cnt, bus.fail_vec}), 32'd0);
        rst_n = 1'b1;

        $display("[TB] healthy gate block");
        applyStimulus("good", 0);

        $display("[TB] xor stuck at 0");
        for (int v = 0; v < 4; v++) fault_mask[v] = golden(2'(v)) & 7'h20;
        applyStimulus("xor_sa0", 0);

        $display("[TB] all responses inverted");
        for (int v = 0; v < 4; v++) fault_mask[v] = 7'h7F;
        applyStimulus("inverted", 0);

        $display("[TB] start re-pulsed while busy");
        for (int v = 0; v < 4; v++) fault_mask[v] = 7'd0;
        applyStimulus("repulse", 3);

        $display("[TB] start held high across DONE");
        @(negedge clk);
        bus.start  = 1'b1;
        first_done = 0;
        for (int c = 1; c <= CYCLE_LIMIT; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                first_done = c;
                break;
            end
        end
        checkOutput("hold_first_done", 32'(first_done), 32'(4 * SETTLE + 1));
        @(negedge clk);
        checkOutput("hold_gap_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        checkOutput("hold_restart_busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < CYCLE_LIMIT; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("hold_second_done", 32'(seen), 32'd1);
        checkOutput("hold_second_pass", 32'(bus.pass), 32'd1);
        repeat (2) @(negedge clk);

        $display("[TB] reset during vector 2");
        for (int v = 0; v < 4; v++) fault_mask[v] = 7'h01;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2 * SETTLE) @(negedge clk);
        checkOutput("rst_pre_vector", 32'({bus.a_o, bus.b_o}), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_async_outputs",
                    32'({bus.busy, bus.done, bus.pass, bus.a_o, bus.b_o, bus.err_cnt, bus.fail_vec}), 32'd0);
        @(negedge clk);
        checkOutput("rst_held_outputs",
                    32'({bus.busy, bus.done, bus.pass, bus.a_o, bus.b_o, bus.err_cnt, bus.fail_vec}), 32'd0);
        rst_n = 1'b1;
        for (int v = 0; v < 4; v++) fault_mask[v] = 7'd0;
        applyStimulus("after_reset", 0);

        $display("[TB] randomized fault masks");
        for (int r = 0; r < 6; r++) begin
            for (int v = 0; v < 4; v++) begin
                fault_mask[v] = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
            end
            applyStimulus($sformatf("rand%0d", r), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/gate_bist_ctrl.md
GATE_BIST_CTRL -- requirements
Module: gate_bist_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 2, meaning cycles each vector is held before gate_i is sampled; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-005 SHALL have port a_o  output  1  operand a driven to the basic-gates block under test.
REQ-006 SHALL have port b_o  output  1  operand b driven to the basic-gates block under test.
REQ-007 SHALL have port gate_i  input  7  responses: [0] and, [1] or, [2] not(a), [3] nand, [4] nor, [5] xor, [6] xnor.
REQ-008 SHALL have port busy  output  1  run in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-010 SHALL have port pass  output  1  last run had zero mismatches; held until next run completes.
REQ-011 SHALL have port err_cnt  output  5  total mismatching response bits in last run (0..28).
REQ-012 SHALL have port fail_vec  output  4  bit k set if vector k had any mismatch.

Function
REQ-013 SHALL apply vectors k=0..3 in order, a_o=k[1], b_o=k[0] (00,01,10,11).
REQ-014 SHALL use FSM states IDLE, RUN, DONE: IDLE->RUN on start=1; RUN->DONE after sampling vector 3; DONE->IDLE after one cycle.
REQ-015 SHALL, on the edge accepting start, clear err_cnt and fail_vec, set busy=1 and drive vector 0 from the next cycle.
REQ-016 SHALL hold each vector for exactly SETTLE cycles and sample gate_i on the edge ending its last cycle; that same edge drives the next vector.
REQ-017 SHALL compare sampled gate_i against the 7-bit expected value for the current (a_o,b_o); err_cnt adds the popcount of the XOR difference; fail_vec[k] set if difference is nonzero.
REQ-018 SHALL, in DONE, assert done=1 for exactly one cycle with busy=0, a_o=b_o=0, and update pass=(err_cnt==0) on the same edge.
REQ-019 SHALL give total latency start-edge to done = 4*SETTLE+1 cycles (SETTLE=2: busy high 8 cycles, done in cycle 9).
REQ-020 SHALL ignore start while busy=1 or during DONE; start held high in IDLE after DONE begins a new run.
REQ-021 SHALL keep err_cnt/fail_vec/pass stable outside RUN; they change only inside a run.

Reset
REQ-022 SHALL, on rst_n=0 at any time including mid-run, immediately force IDLE, a_o=0, b_o=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0.
REQ-023 SHALL resume accepting start on the first rising edge after rst_n deasserts.

Configuration
REQ-024 SHALL support macro GATE_BIST_STOP_ON_FAIL_EN: when defined, the first vector with any mismatch ends the run (RUN->DONE on that sample edge, later vectors not applied); when undefined, all 4 vectors always run.

Structure
REQ-025 SHALL place in package gate_bist_pkg: FSM state enum, gate index constants (AND_IDX..XNOR_IDX), NUM_GATES=7, NUM_VEC=4.
REQ-026 SHALL instantiate one sub-module gate_bist_ref computing the 7-bit expected response from (a,b) combinationally.

Verification
REQ-027 SHALL test correct gate model, SETTLE=2, start pulse -> busy 8 cycles, done in cycle 9, pass=1, err_cnt=0, fail_vec=4'b0000.
REQ-028 SHALL test xor output stuck at 0 -> pass=0, err_cnt=2, fail_vec=4'b0110.
REQ-029 SHALL test all seven responses inverted -> err_cnt=28, fail_vec=4'b1111, pass=0.
REQ-030 SHALL test rst_n low during vector 2, then start -> all outputs zero during reset; next run completes normally with pass=1.
REQ-031 SHALL test start re-pulsed while busy -> ignored, done occurs once at cycle 9.
REQ-032 SHALL test, with GATE_BIST_STOP_ON_FAIL_EN and xor stuck at 0 -> done after vector 1 sample (cycle 5), err_cnt=1, fail_vec=4'b0010.
